mod_reducer: RTL and testbench
==============================

Name: mod_reducer

Overview:
- Sequential modular-reduction stage directly downstream of the multiplier adapter.
- Consumes the 2*width-bit product and returns the product mod p, a width-bit residue, for the MSM field-arithmetic path.
- Bit-serial restoring reduction: one product bit per cycle, MSB first, with a conditional subtract of p each cycle.
- Handshake matches the multiplier: enable to start, done to report completion.

Parameters:
- width, 128, modulus/residue width; the product input is 2*width bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ab  input  2*width  product to reduce; sampled only when a start is accepted.
- p  input  width  modulus; sampled together with ab.
- enable  input  1  start request.
- r  output  width  residue ab mod p; valid while done=1, held until the next start.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: r=0, done=0, FSM=IDLE, counter=0, accumulator=0.
- Reset mid-operation aborts the computation and returns to these reset values.
- FSM states: IDLE and RUN.
- IDLE, enable=0: hold state; done goes low after its pulse cycle.
- IDLE, enable=1 at clock edge k:
  - latch ab into a shift register and p into a modulus register;
  - clear the accumulator acc (width+1 bits) and the counter;
  - go to RUN.
- enable is ignored while in RUN; no queueing.
- RUN, each edge:
  - t = {acc[width-1:0], next MSB of the shift register} (width+1 bits);
  - if t >= p_latched then acc = t - p_latched, else acc = t;
  - shift the register left by 1 and increment the counter.
- Invariants: acc < p, so t < 2p and fits in width+1 bits. No wider arithmetic is needed.
- RUN ends after 2*width bit steps:
  - on the final step, r takes the new acc[width-1:0], done=1, FSM goes to IDLE;
  - latency is 2*width edges from the accept edge: done is high in the cycle after edge k+2*width.
- Back-to-back: enable=1 in the done cycle is accepted at that edge. Minimum issue interval is 2*width+1 cycles.
- Boundary conditions:
  - p=0 at accept: skip RUN; r=0, done=1 in the cycle after edge k.
  - p=1: r=0 after full latency.
  - ab=0: r=0 after full latency.
  - ab changing during RUN has no effect.
- Counter width: $clog2(2*width)+1.

Optional Feature:
- Macro: MOD_REDUCER_ZERO_SKIP_EN.
- Defined: at accept, if ab[2*width-1:width]==0 and ab[width-1:0] < p (with p != 0), skip RUN. r=ab[width-1:0] and done=1 in the cycle after edge k (latency 1).
- Undefined: every nonzero-p operation takes 2*width cycles; results are identical either way.

Decomposition:
- Shared package msm_pkg:
  - FSM state typedef (IDLE, RUN);
  - constant MSM_DEFAULT_WIDTH=128.
- Natural sub-module mod_reducer_step: combinational {acc, bit} → conditional subtract of p, parameterised by width. Reusable later for a radix-2^k variant.

Test Plan:
- width=8, p=251, ab=16'hFFFF, enable one cycle → done pulses exactly 16 cycles after the accept edge with r=24; done low before and after.
- width=8, p=251, ab=16'h1234 → r=142; r stays 142 after done until the next start.
- width=8, p=0, ab=16'h1234 → r=0, done in the cycle after accept. Then p=1, ab=16'h00FF → r=0 after 16 cycles.
- enable held high, ab=16'hFFFF then 16'h1234 (p=251) → done pulses 17 cycles apart, r=24 then r=142; enable pulses during RUN are ignored.
- Reset asserted 5 cycles into RUN → next cycle r=0, done=0, IDLE. A fresh start with ab=16'hFFFF, p=251 → r=24.
- ab=16'd200, p=251 → with MOD_REDUCER_ZERO_SKIP_EN, r=200 in 1 cycle; without it, r=200 after 16 cycles. Randomized comparison against the reference ab % p in both builds.

Source files
------------

// File: rtl/msm_pkg.sv
// Shared definitions for the MSM field-arithmetic path: FSM state type and default width.
package msm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } msm_state_e;

    localparam int MSM_DEFAULT_WIDTH = 128;

endpackage

// File: rtl/mod_reducer_step.sv
// One restoring-reduction step: shift a product bit into the accumulator and
// conditionally subtract the modulus. Purely combinational.
module mod_reducer_step #(
    parameter int width = 128
) (
    input  logic [width-1:0] acc,
    input  logic             bit_in,
    input  logic [width-1:0] p,
    output logic [width-1:0] acc_next
);

    logic [width:0] t_s;
    logic [width:0] p_ext_s;

    // Since acc < p, t < 2p: one conditional subtract restores acc < p and the
    // result always fits back into width bits.
    always_comb begin
        t_s     = {acc, bit_in};
        p_ext_s = {1'b0, p};
        if (t_s >= p_ext_s) begin
            acc_next = width'(t_s - p_ext_s);
        end else begin
            acc_next = t_s[width-1:0];
        end
    end

endmodule

// File: rtl/mod_reducer.sv
// Bit-serial restoring modular reducer: r = ab mod p, one product bit per cycle, MSB first.
// Optional build macro MOD_REDUCER_ZERO_SKIP_EN: finish in one cycle when ab already lies below p.
module mod_reducer
    import msm_pkg::*;
#(
    parameter int width = MSM_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*width-1:0] ab,
    input  logic [width-1:0]   p,
    input  logic               enable,
    output logic [width-1:0]   r,
    output logic               done
);

    localparam int CW = $clog2(2*width) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(2*width - 1);

    msm_state_e         state_r;
    msm_state_e         state_nxt_s;
    logic [2*width-1:0] shreg_r;
    logic [width-1:0]   p_r;
    logic [width-1:0]   acc_r;
    logic [CW-1:0]      cnt_r;
    logic [width-1:0]   acc_next_s;
    logic               last_s;
    logic               skip_s;
    logic               zs_s;
    logic [width-1:0]   skip_val_s;

    mod_reducer_step #(
        .width (width)
    ) u_step (
        .acc      (acc_r),
        .bit_in   (shreg_r[2*width-1]),
        .p        (p_r),
        .acc_next (acc_next_s)
    );

    // Decide at accept time whether the serial pass can be bypassed.
    always_comb begin
`ifdef MOD_REDUCER_ZERO_SKIP_EN
        zs_s = (p != {width{1'b0}}) && (ab[2*width-1:width] == {width{1'b0}})
               && (ab[width-1:0] < p);
`else
        zs_s = 1'b0;
`endif
        skip_s = (p == {width{1'b0}}) || zs_s;
        if (zs_s) begin
            skip_val_s = ab[width-1:0];
        end else begin
            skip_val_s = {width{1'b0}};
        end
        last_s = (cnt_r == LAST_STEP);
    end

    // Next-state logic for the IDLE/RUN controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable && !skip_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: operand capture, serial reduction and registered result/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {(2*width){1'b0}};
            p_r     <= {width{1'b0}};
            acc_r   <= {width{1'b0}};
            cnt_r   <= {CW{1'b0}};
            r       <= {width{1'b0}};
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        shreg_r <= ab;
                        p_r     <= p;
                        acc_r   <= {width{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        if (skip_s) begin
                            r    <= skip_val_s;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_r   <= acc_next_s;
                    shreg_r <= {shreg_r[2*width-2:0], 1'b0};
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    done    <= last_s;
                    if (last_s) begin
                        r <= acc_next_s;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reducer.sv
// Directed bench for mod_reducer at width=8; expected residues computed by hand or as ab % p.
module tb_mod_reducer;

    logic        clk;
    logic        reset;
    logic [15:0] ab;
    logic [7:0]  p;
    logic        enable;
    logic [7:0]  r;
    logic        done;

    int err_cnt = 0;
    int chk_cnt = 0;

    mod_reducer #(.width(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .ab     (ab),
        .p      (p),
        .enable (enable),
        .r      (r),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation; lat counts clock edges from the accept edge to the edge raising done.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] m,
                          input logic [7:0] exp_r, input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        ab = a; p = m; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0; ab = 16'hA5A5; p = 8'h07;
        while (!done && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_r"}, {24'd0, r}, {24'd0, exp_r});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    function automatic int exp_latency(input logic [15:0] a, input logic [7:0] m);
        if (m == 8'd0) return 0;
`ifdef MOD_REDUCER_ZERO_SKIP_EN
        if (a[15:8] == 8'd0 && a[7:0] < m) return 0;
`endif
        return 16;
    endfunction

    initial begin
        int t1, t2, n;
        logic [7:0] r1, r2;
        logic [15:0] ra;
        logic [7:0]  rp;

        reset = 1'b1; ab = 16'd0; p = 8'd0; enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_r", {24'd0, r}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        run_op("ffff", 16'hFFFF, 8'd251, 8'd24, 16);
        run_op("h1234", 16'h1234, 8'd251, 8'd142, 16);
        repeat (5) @(negedge clk);
        chk("hold_r", {24'd0, r}, 32'd142);
        chk("hold_done", {31'd0, done}, 32'd0);

        run_op("p0", 16'h1234, 8'd0, 8'd0, 0);
        run_op("p1", 16'h00FF, 8'd1, 8'd0, 16);
        run_op("ab0", 16'h0000, 8'd251, 8'd0, 16);
        run_op("d200", 16'd200, 8'd251, 8'd200, exp_latency(16'd200, 8'd251));

        // Back-to-back with enable held high; the second start is taken in the done cycle.
        t1 = -1; t2 = -1; r1 = 8'd0; r2 = 8'd0; n = 0;
        @(negedge clk);
        ab = 16'hFFFF; p = 8'd251; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ab = 16'h1234;
        while (t2 < 0 && n < 60) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = n; r1 = r;
                end else begin
                    t2 = n; r2 = r;
                end
            end
            if (t2 < 0) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
        end
        enable = 1'b0;
        chk("b2b_t1", t1, 16);
        chk("b2b_r1", {24'd0, r1}, 32'd24);
        chk("b2b_t2", t2, 33);
        chk("b2b_r2", {24'd0, r2}, 32'd142);
        repeat (20) @(negedge clk);

        // Abort mid-run with reset, then restart.
        @(negedge clk);
        ab = 16'hFFFF; p = 8'd251; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_r", {24'd0, r}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) chk("abort_stray_done", {31'd0, done}, 32'd0);
        end
        run_op("restart", 16'hFFFF, 8'd251, 8'd24, 16);

        // Pseudo-random operands against the arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rp = 8'($urandom);
            if (i % 4 == 0) ra = {8'd0, ra[7:0]};
            if (i == 5) rp = 8'd0;
            run_op($sformatf("rnd%0d", i), ra, rp,
                   (rp == 8'd0) ? 8'd0 : 8'(ra % {8'd0, rp}), exp_latency(ra, rp));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
